// File: rtl/alu_writeback_stage_pkg.sv
// Shared widths, opcode encodings and opcode classification helpers for the
// ALU writeback stage and its branch resolver.
package alu_writeback_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 6;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OP_W-1:0] OP_INC  = 4'b0101;
  localparam logic [OP_W-1:0] OP_NEG  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0111;
  localparam logic [OP_W-1:0] OP_J    = 4'b1000;
  localparam logic [OP_W-1:0] OP_BRZ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_JM   = 4'b1010;
  localparam logic [OP_W-1:0] OP_BRN  = 4'b1011;
  localparam logic [OP_W-1:0] OP_LD   = 4'b1110;
  localparam logic [OP_W-1:0] OP_SVPC = 4'b1111;

  // Where a redirect address comes from; HOLD means "not a branch opcode".
  typedef enum logic [1:0] {
    TSEL_HOLD   = 2'd0,
    TSEL_TARGET = 2'd1,
    TSEL_MEM    = 2'd2
  } target_sel_e;

  function automatic logic writes_rf(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_INC) || (op == OP_NEG) ||
           (op == OP_SUB) || (op == OP_LD)  || (op == OP_SVPC);
  endfunction

  function automatic logic sets_flags(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_INC) || (op == OP_NEG) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_writeback_stage_branch_resolve.sv
// Combinational branch decision: maps an opcode and the current flag register
// to a taken bit and the source of the redirect address.
module branch_resolve
  import alu_writeback_stage_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_z,
  input  logic            flag_n,
  output logic            taken,
  output target_sel_e     target_sel
);

  always_comb begin
    taken      = 1'b0;
    target_sel = TSEL_HOLD;
    case (opcode)
      OP_J: begin
        taken      = 1'b1;
        target_sel = TSEL_TARGET;
      end
      OP_JM: begin
        taken      = 1'b1;
        target_sel = TSEL_MEM;
      end
      OP_BRZ: begin
        taken      = flag_z;
        target_sel = TSEL_TARGET;
      end
      OP_BRN: begin
        taken      = flag_n;
        target_sel = TSEL_TARGET;
      end
      default: begin
        taken      = 1'b0;
        target_sel = TSEL_HOLD;
      end
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage: registers one EX-stage instruction per cycle, updates the
// architectural flags, resolves branches and counts retired instructions.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_n,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_target,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [CNT_W-1:0]  retire_count
);

  // Handshake: an instruction is captured on a rising edge when in_valid=1 and
  // neither stall nor flush is asserted; there is no back-pressure output,
  // stall is the upstream's only hold mechanism and flush wins over stall.
  logic        res_taken;
  target_sel_e res_sel;

  branch_resolve u_branch_resolve (
    .opcode     (in_opcode),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .taken      (res_taken),
    .target_sel (res_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      flag_z       <= 1'b0;
      flag_n       <= 1'b0;
      br_taken     <= 1'b0;
      br_target    <= '0;
      retire_count <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      // Bubble: destination, data and redirect address keep their last values.
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      br_taken <= 1'b0;
    end else if (stall) begin
      br_taken <= 1'b0;
    end else begin
      wb_valid     <= 1'b1;
      wb_we        <= writes_rf(in_opcode);
      wb_rd        <= in_rd;
      wb_data      <= (in_opcode == OP_LD) ? in_mem_data : in_result;
      br_taken     <= res_taken;
      retire_count <= retire_count + 1'b1;
      if (sets_flags(in_opcode)) begin
        flag_z <= in_z;
        flag_n <= in_n;
      end
      if (res_sel == TSEL_TARGET) begin
        br_target <= in_target;
      end else if (res_sel == TSEL_MEM) begin
        br_target <= in_mem_data;
      end
    end
  end

endmodule
